// File: rtl/axis_recv_pkg.sv
// Shared types for the AXI-Stream receive dispatcher.
// FSM state encoding and destination buffer indices.
package axis_recv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE,
        ST_WAIT_LOW
    } recv_state_e;

    localparam int DEST_IFM    = 0;
    localparam int DEST_WEIGHT = 1;
    localparam int DEST_BIAS   = 2;
    localparam int DEST_LRELU  = 3;

endpackage

// File: rtl/axis_recv_wr_stage.sv
// Registered buffer write port: one-hot dest decode, address add, data reg.
// An out-of-range dest decodes to an all-zero strobe, so its beats are drained.
module axis_recv_wr_stage
    import axis_recv_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_BIT = 16,
    parameter int NUM_DEST = 4,
    parameter int DEST_W   = $clog2(NUM_DEST)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic [DEST_W-1:0]   dest,
    input  logic [ADDR_BIT-1:0] base,
    input  logic [ADDR_BIT-1:0] idx,
    input  logic [DATA_W-1:0]   data,
    output logic [NUM_DEST-1:0] write_enable,
    output logic [ADDR_BIT-1:0] write_addr,
    output logic [DATA_W-1:0]   write_data
);

    logic [NUM_DEST-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            onehot[i] = (dest == DEST_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_enable <= '0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= '0;
            if (accept) begin
                write_enable <= onehot;
                write_addr   <= base + idx;
                write_data   <= data;
            end
        end
    end

endmodule

// File: rtl/axis_recv_dispatch.sv
// AXI-Stream receive engine steering beats to one of NUM_DEST buffers.
// Define RECV_DISPATCH_ERR_CHECK_EN to enable tlast/length and dest checks.
module axis_recv_dispatch
    import axis_recv_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_BIT = 16,
    parameter int NUM_DEST = 4,
    parameter int DEST_W   = $clog2(NUM_DEST)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                recv_enable,
    input  logic [DEST_W-1:0]   dest_sel,
    input  logic [ADDR_BIT-1:0] base_addr,
    input  logic [ADDR_BIT-1:0] beat_len,
    input  logic                s_axis_tvalid,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [NUM_DEST-1:0] write_enable,
    output logic [ADDR_BIT-1:0] write_addr,
    output logic [DATA_W-1:0]   write_data,
    output logic                recv_busy,
    output logic                recv_done,
    output logic [ADDR_BIT-1:0] beat_count,
    output logic                tlast_err
);

    recv_state_e         state;
    recv_state_e         state_nxt;
    logic                en_q;
    logic [DEST_W-1:0]   dest_q;
    logic [ADDR_BIT-1:0] base_q;
    logic [ADDR_BIT-1:0] len_q;
    logic [ADDR_BIT-1:0] cnt_inc;
    logic                start;
    logic                hs;
    logic                len_hit;
    logic                term;

    assign start   = (state == ST_IDLE) && recv_enable && !en_q;
    assign hs      = (state == ST_RECV) && s_axis_tvalid;
    assign cnt_inc = beat_count + ADDR_BIT'(1);
    assign len_hit = (len_q != '0) && (cnt_inc == len_q);
    assign term    = hs && (s_axis_tlast || len_hit);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (!recv_enable) state_nxt = ST_IDLE;
                else if (term) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!recv_enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // en_q resets high so a level held across reset is not taken as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            en_q       <= 1'b1;
            dest_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            beat_count <= '0;
        end else begin
            state <= state_nxt;
            en_q  <= recv_enable;
            if (start) begin
                dest_q     <= dest_sel;
                base_q     <= base_addr;
                len_q      <= beat_len;
                beat_count <= '0;
            end else if (hs) begin
                beat_count <= cnt_inc;
            end
        end
    end

    assign s_axis_tready = (state == ST_RECV);
    assign recv_busy     = (state == ST_RECV);
    assign recv_done     = (state == ST_DONE);

`ifdef RECV_DISPATCH_ERR_CHECK_EN
    logic dest_bad;

    assign dest_bad = {1'b0, dest_sel} >= (DEST_W + 1)'(NUM_DEST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tlast_err <= 1'b0;
        end else if (start) begin
            tlast_err <= dest_bad;
        end else if (hs && (len_q != '0) && (s_axis_tlast != len_hit)) begin
            tlast_err <= 1'b1;
        end
    end
`else
    assign tlast_err = 1'b0;
`endif

    axis_recv_wr_stage #(
        .DATA_W   (DATA_W),
        .ADDR_BIT (ADDR_BIT),
        .NUM_DEST (NUM_DEST),
        .DEST_W   (DEST_W)
    ) u_wr (
        .clk          (clk),
        .rst          (rst),
        .accept       (hs),
        .dest         (dest_q),
        .base         (base_q),
        .idx          (beat_count),
        .data         (s_axis_tdata),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

endmodule
